// File: rtl/game_flow_fsm_if.sv
// Player-input / screen-output bundle of the Memory Game flow controller.
// The controller attaches as slave; the menu/board front-end attaches as master.
interface game_flow_fsm_if #(
  parameter int N_CARDS = 16,
  parameter int IDX_W   = 4,
  parameter int SYM_W   = 3,
  parameter int MOVES_W = 8
);
  logic               start_button_pressed;
  logic               card_click;
  logic [IDX_W-1:0]   card_idx;
  logic [SYM_W-1:0]   card_symbol;
  logic               draw_start_button;
  logic               draw_cards;
  logic               draw_game_over;
  logic [N_CARDS-1:0] card_up;
  logic [N_CARDS-1:0] card_matched;
  logic [MOVES_W-1:0] moves;
  logic [IDX_W-1:0]   pairs_found;

  modport master (
    output start_button_pressed, card_click, card_idx, card_symbol,
    input  draw_start_button, draw_cards, draw_game_over,
    input  card_up, card_matched, moves, pairs_found
  );

  modport slave (
    input  start_button_pressed, card_click, card_idx, card_symbol,
    output draw_start_button, draw_cards, draw_game_over,
    output card_up, card_matched, moves, pairs_found
  );
endinterface

// File: rtl/game_flow_fsm.sv
// Memory Game flow controller: menu, two picks, compare, mismatch hold, game over.
// Build macro GAME_FLOW_CLICK_SKIP_EN: any click during the mismatch hold ends it early.
module game_flow_fsm #(
  parameter int N_CARDS     = 16,
  parameter int IDX_W       = 4,
  parameter int SYM_W       = 3,
  parameter int HOLD_CYCLES = 65000000,
  parameter int MOVES_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  game_flow_fsm_if.slave bus
);

  localparam int IDX_SPAN = 2 ** IDX_W;
  localparam int TMR_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] ALL_PAIRS = IDX_W'(N_CARDS / 2);

`ifdef GAME_FLOW_CLICK_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    PICK1 = 3'd1,
    PICK2 = 3'd2,
    CMP   = 3'd3,
    HOLD  = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t             state;
  logic               draw_start_button;
  logic               draw_cards;
  logic               draw_game_over;
  logic [N_CARDS-1:0] card_up;
  logic [N_CARDS-1:0] card_matched;
  logic [MOVES_W-1:0] moves;
  logic [IDX_W-1:0]   pairs_found;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   second_idx;
  logic [SYM_W-1:0]   first_sym;
  logic [SYM_W-1:0]   second_sym;
  logic [TMR_W-1:0]   timer;

  logic [IDX_SPAN-1:0] up_ext;
  logic [IDX_SPAN-1:0] matched_ext;
  logic                in_range;
  logic                valid_click;
  logic [IDX_W-1:0]    pairs_next;
  logic [N_CARDS-1:0]  pick_mask;

  function automatic logic [N_CARDS-1:0] card_bit(input logic [IDX_W-1:0] idx);
    return {{(N_CARDS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Click qualification; masks are widened so any index value is safe to look up.
  always_comb begin
    up_ext      = IDX_SPAN'(card_up);
    matched_ext = IDX_SPAN'(card_matched);
    in_range    = (32'(bus.card_idx) < 32'(N_CARDS));
    valid_click = bus.card_click & in_range
                & ~up_ext[bus.card_idx] & ~matched_ext[bus.card_idx];
    pairs_next  = pairs_found + 1'b1;
    pick_mask   = card_bit(first_idx) | card_bit(second_idx);
  end

  // Game-flow state machine with registered screen flags and board bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= MENU;
      draw_start_button <= 1'b0;
      draw_cards        <= 1'b0;
      draw_game_over    <= 1'b0;
      card_up           <= '0;
      card_matched      <= '0;
      moves             <= '0;
      pairs_found       <= '0;
      first_idx         <= '0;
      second_idx        <= '0;
      first_sym         <= '0;
      second_sym        <= '0;
      timer             <= '0;
    end else begin
      draw_start_button <= (state == MENU);
      // the board stays on screen through the one-cycle compare as well
      draw_cards        <= (state != MENU);
      draw_game_over    <= (state == OVER);

      case (state)
        MENU, OVER: begin
          if (bus.start_button_pressed) begin
            card_up      <= '0;
            card_matched <= '0;
            moves        <= '0;
            pairs_found  <= '0;
            state        <= PICK1;
          end
        end
        PICK1: begin
          if (valid_click) begin
            card_up   <= card_up | card_bit(bus.card_idx);
            first_idx <= bus.card_idx;
            first_sym <= bus.card_symbol;
            state     <= PICK2;
          end
        end
        PICK2: begin
          // the first card is already face-up, so a valid click is always a different card
          if (valid_click) begin
            card_up    <= card_up | card_bit(bus.card_idx);
            second_idx <= bus.card_idx;
            second_sym <= bus.card_symbol;
            state      <= CMP;
          end
        end
        CMP: begin
          if (moves != {MOVES_W{1'b1}}) begin
            moves <= moves + 1'b1;
          end
          if (first_sym == second_sym) begin
            card_matched <= card_matched | pick_mask;
            pairs_found  <= pairs_next;
            state        <= (pairs_next == ALL_PAIRS) ? OVER : PICK1;
          end else begin
            timer <= HOLD_LOAD;
            state <= HOLD;
          end
        end
        HOLD: begin
          if ((timer == '0) || (SKIP_EN && bus.card_click)) begin
            card_up <= card_up & ~pick_mask;
            timer   <= '0;
            state   <= PICK1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= MENU;
        end
      endcase
    end
  end

  assign bus.draw_start_button = draw_start_button;
  assign bus.draw_cards        = draw_cards;
  assign bus.draw_game_over    = draw_game_over;
  assign bus.card_up           = card_up;
  assign bus.card_matched      = card_matched;
  assign bus.moves             = moves;
  assign bus.pairs_found       = pairs_found;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm: expected outputs are queued per cycle and
// compared by a negedge scoreboard process.
module tb_game_flow_fsm;
  localparam int N_CARDS     = 16;
  localparam int IDX_W       = 5;
  localparam int SYM_W       = 3;
  localparam int HOLD_CYCLES = 10;
  localparam int MOVES_W     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          due;
    string       tag;
    logic        ds;
    logic        dc;
    logic        dg;
    logic [15:0] up;
    logic [15:0] mat;
    logic [1:0]  moves;
    logic [4:0]  pairs;
  } exp_t;

  exp_t q[$];

  logic        m_ds, m_dc, m_dg;
  logic [15:0] m_up, m_mat;
  logic [1:0]  m_moves;
  logic [4:0]  m_pairs;

  game_flow_fsm_if #(.N_CARDS(N_CARDS), .IDX_W(IDX_W), .SYM_W(SYM_W), .MOVES_W(MOVES_W)) bus ();

  game_flow_fsm #(
    .N_CARDS(N_CARDS), .IDX_W(IDX_W), .SYM_W(SYM_W),
    .HOLD_CYCLES(HOLD_CYCLES), .MOVES_W(MOVES_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, string field, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed 0x%0h expected 0x%0h", tag, field, obs, exp);
    end
  endtask

  // Scoreboard: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        chk(q[i].tag, "draw_start_button", 32'(bus.draw_start_button), 32'(q[i].ds));
        chk(q[i].tag, "draw_cards",        32'(bus.draw_cards),        32'(q[i].dc));
        chk(q[i].tag, "draw_game_over",    32'(bus.draw_game_over),    32'(q[i].dg));
        chk(q[i].tag, "card_up",           32'(bus.card_up),           32'(q[i].up));
        chk(q[i].tag, "card_matched",      32'(bus.card_matched),      32'(q[i].mat));
        chk(q[i].tag, "moves",             32'(bus.moves),             32'(q[i].moves));
        chk(q[i].tag, "pairs_found",       32'(bus.pairs_found),       32'(q[i].pairs));
        q.delete(i);
      end
    end
  end

  function automatic logic [15:0] bit16(int i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  // Queue the model as next cycle's expectation, advance one cycle, release pulses.
  task automatic tick(string tag);
    exp_t e;
    e.due = cyc + 1;  e.tag = tag;
    e.ds = m_ds;      e.dc = m_dc;   e.dg = m_dg;
    e.up = m_up;      e.mat = m_mat; e.moves = m_moves; e.pairs = m_pairs;
    q.push_back(e);
    @(negedge clk);
    bus.start_button_pressed = 1'b0;
    bus.card_click           = 1'b0;
    bus.card_idx             = 5'd0;
    bus.card_symbol          = 3'd0;
  endtask

  task automatic click(int idx, int sym);
    bus.card_click  = 1'b1;
    bus.card_idx    = 5'(idx);
    bus.card_symbol = 3'(sym);
  endtask

  task automatic mismatch(int a, int sa, int b, int sb, string tag, bit hold_click);
    click(a, sa); m_up = m_up | bit16(a); tick({tag, "_a"});
    click(b, sb); m_up = m_up | bit16(b); tick({tag, "_b"});
    if (m_moves != 2'd3) m_moves = m_moves + 2'd1;
    tick({tag, "_cmp"});
    for (int i = 0; i < HOLD_CYCLES - 1; i++) begin
      if (hold_click && i == 3) click(5, 0);
      tick({tag, "_hold"});
    end
    m_up = m_up & ~(bit16(a) | bit16(b));
    tick({tag, "_end"});
  endtask

  task automatic match_pair(int a, int b, int s, string tag);
    click(a, s); m_up = m_up | bit16(a); tick({tag, "_a"});
    click(b, s); m_up = m_up | bit16(b); tick({tag, "_b"});
    m_mat   = m_mat | bit16(a) | bit16(b);
    m_pairs = m_pairs + 5'd1;
    if (m_moves != 2'd3) m_moves = m_moves + 2'd1;
    tick({tag, "_cmp"});
    if (m_pairs == 5'd8) begin
      m_dg = 1'b1;
      tick({tag, "_over"});
    end
  endtask

  initial begin
    bus.start_button_pressed = 1'b0;
    bus.card_click           = 1'b0;
    bus.card_idx             = 5'd0;
    bus.card_symbol          = 3'd0;
    m_ds = 1'b0; m_dc = 1'b0; m_dg = 1'b0;
    m_up = 16'h0000; m_mat = 16'h0000; m_moves = 2'd0; m_pairs = 5'd0;

    @(negedge clk);
    tick("reset");
    tick("reset");

    rst  = 1'b0;
    m_ds = 1'b1;
    for (int i = 0; i < 5; i++) tick("menu");

    bus.start_button_pressed = 1'b1;
    tick("start_menu");
    m_ds = 1'b0; m_dc = 1'b1;
    tick("start_board");

    // matching pair 2/9 gives masks 0x0204
    match_pair(2, 9, 5, "pair29");

    // mismatch 0/1 with an ignored click during the hold
    mismatch(0, 1, 1, 2, "mis01", 1'b1);

    // invalid clicks in PICK1 and PICK2 leave everything unchanged
    click(2, 5);  tick("inv_matched");
    click(16, 0); tick("inv_range");
    click(3, 4);  m_up = m_up | bit16(3); tick("pick3");
    click(3, 4);  tick("inv_same");
    click(9, 5);  tick("inv_matched2");
    click(16, 4); tick("inv_range2");
    click(4, 4);  m_up = m_up | bit16(4); tick("pick4");
    m_mat   = m_mat | bit16(3) | bit16(4);
    m_pairs = m_pairs + 5'd1;
    m_moves = m_moves + 2'd1;
    tick("match34");

    // four more mismatches: moves stays saturated at 3
    for (int k = 0; k < 4; k++) mismatch(0, 1, 1, 2, "sat", 1'b0);

    // finish the board
    match_pair(0, 1, 1, "g01");
    match_pair(5, 6, 2, "g56");
    match_pair(7, 8, 3, "g78");
    match_pair(10, 11, 6, "g1011");
    match_pair(12, 13, 7, "g1213");
    match_pair(14, 15, 0, "g1415");

    click(0, 1); tick("over_click");

    // start wins over a simultaneous click in OVER
    bus.start_button_pressed = 1'b1;
    click(0, 1);
    m_up = 16'h0000; m_mat = 16'h0000; m_moves = 2'd0; m_pairs = 5'd0;
    tick("restart");
    m_dg = 1'b0;
    tick("restart_board");

    // reset in the middle of a hold
    click(0, 1); m_up = 16'h0001; tick("rh_a");
    click(1, 2); m_up = 16'h0003; tick("rh_b");
    m_moves = 2'd1; tick("rh_cmp");
    tick("rh_hold");
    tick("rh_hold");
    rst = 1'b1;
    m_ds = 1'b0; m_dc = 1'b0; m_dg = 1'b0;
    m_up = 16'h0000; m_mat = 16'h0000; m_moves = 2'd0; m_pairs = 5'd0;
    tick("rst_hold");
    rst  = 1'b0;
    m_ds = 1'b1;
    tick("rst_menu");

    @(negedge clk);
    @(negedge clk);
    chk("end", "queue_left", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
